vga_timing_detect: RTL and testbench
====================================

Name: vga_timing_detect

Overview:
Receive-side counterpart of the VGA timing generator. Samples an incoming hsync/vsync/de stream, recovers per-pixel position (hcount/vcount) aligned to a delayed de, measures line and frame geometry, and flags lock once geometry is stable over consecutive frames. Used ahead of capture, scaler or overlay logic that needs pixel coordinates from an external or looped-back video source.

Parameters:
HSZ, 10, width of recovered hcount_o
VSZ, 9, width of recovered vcount_o
HMSZ, 12, width of horizontal measurement counters (clocks), also sets watchdog length 2^HMSZ
VMSZ, 11, width of vertical measurement counters (lines)
LOCK_FRAMES, 2, consecutive matching frames required to assert lock_o

Ports:
clk_i  in  1  pixel clock; hsync_i, vsync_i and de_i are synchronous to it
rst_i  in  1  synchronous active-high reset
hsync_i  in  1  horizontal sync, active low
vsync_i  in  1  vertical sync, active low
de_i  in  1  display enable, active high
de_o  out  1  de_i delayed 2 clocks, gated by state
hcount_o  out  HSZ  pixel index within active line, valid while de_o
vcount_o  out  VSZ  active line index within frame, valid while de_o
frame_o  out  1  one-cycle pulse on detected vsync assertion
h_total_o  out  HMSZ  clocks between successive hsync falling edges
h_active_o  out  HMSZ  de-high clocks per line
h_sync_o  out  HMSZ  hsync low width in clocks
v_total_o  out  VMSZ  hsync falling edges between successive vsync falling edges
v_active_o  out  VMSZ  lines containing de per frame
v_sync_o  out  VMSZ  vsync low width in lines
lock_o  out  1  geometry stable

Behaviour:
- Reset (rst_i=1 at clock edge): all outputs 0, all counters 0, stored previous-frame values 0 with prev_valid=0, state SEARCH. Reset overrides all other actions in that cycle.
- Stage 1 registers inputs (hs_r, vs_r, de_r); stage 2 holds previous copies. Edges are detected between stage 1 and stage 2, giving a latency of 2 clocks from pins to any derived output.
- Horizontal: hclk counter increments every clock and saturates at all-ones. On an hsync falling edge, capture line total and clear hclk to 1. Sync width is captured on the hsync rising edge. Line active width counts de_r-high clocks and is captured on the de falling edge.
- Vertical: the line counter increments on each hsync falling edge. The active-line counter increments on each de falling edge. The vsync-width counter counts hsync falling edges while vsync is low and is captured on the vsync rising edge. All counters saturate.
- On a vsync falling edge (frame edge): frame_o=1 for 1 cycle. If state is not SEARCH, *_o measurements are updated in that same cycle with the last completed line and frame values. Frame counters then clear.
- Position: de_o = de_r when state is not SEARCH, else 0. hcount_o=0 on the first de_o cycle of a line, then +1 per de_o cycle. vcount_o=0 on the first active line after a frame edge, then +1 per line. Both hold while de_o=0 and wrap modulo 2^HSZ / 2^VSZ.
- FSM:
  - SEARCH: lock_o=0. On the first frame edge, go to MEASURE without capturing measurements.
  - MEASURE: at each frame edge, compare (h_total, h_active, v_total, v_active) with the stored previous values. If they match and prev_valid=1, match_cnt+1; otherwise match_cnt=0. Store the new values and set prev_valid=1. When match_cnt reaches LOCK_FRAMES, go to LOCKED and assert lock_o in the same cycle as frame_o.
  - LOCKED: on any mismatch at a frame edge, go to MEASURE with lock_o=0 and match_cnt=0. The new values are stored.
  - Any state: if hclk saturates (no hsync edge for 2^HMSZ-1 clocks), go to SEARCH with lock_o=0, prev_valid=0, match_cnt=0. Measurement outputs retain their last values.
- Simultaneous hsync and vsync falling edges are the normal case. The line count includes that hsync edge before the frame capture.

Test Plan:
All scenarios use a small test generator with H 16/2/4/3 (total 25) and V 8/1/2/2 (total 13).

1. Reset, then stream frames → frame_o pulses every 325 clocks. On the 2nd frame edge: h_total_o=25, h_active_o=16, h_sync_o=4, v_total_o=13, v_active_o=8, v_sync_o=2. lock_o rises on the 4th frame edge, in the frame_o cycle.
2. Locked stream → exactly 128 de_o cycles per frame. First cycle has hcount_o=0, vcount_o=0; last has hcount_o=15, vcount_o=7. de_o lags de_i by exactly 2 clocks.
3. After lock, change H back porch 3→4 → at the next frame edge lock_o=0 and h_total_o=26. Relock occurs 2 frame edges later.
4. Hold hsync_i=1 and vsync_i=1 after lock → lock_o=0 within 4096 clocks and de_o stays 0. Measurement outputs keep 25/16/4/13/8/2.
5. Pulse rst_i for 1 cycle mid-line during de → next cycle all outputs are 0. de_o stays 0 until the first frame edge, and the next frame's position starts at 0,0.
6. de_i forced low for an entire frame → v_active_o=0 and h_active_o holds the last captured value. The mismatch at that frame edge deasserts lock_o.

Source files
------------

// File: rtl/vga_timing_detect.sv
// Receive-side VGA timing recovery: pixel position, line/frame geometry
// measurement and a lock flag for a stable incoming hsync/vsync/de stream.
//
// state     | meaning
// S_SEARCH  | no frame reference yet; de_o blocked, lock_o low
// S_MEASURE | comparing each frame's geometry with the previous frame
// S_LOCKED  | geometry repeated for LOCK_FRAMES consecutive frame edges
module vga_timing_detect #(
    parameter int HSZ         = 10,
    parameter int VSZ         = 9,
    parameter int HMSZ        = 12,
    parameter int VMSZ        = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            hsync_i,
    input  logic            vsync_i,
    input  logic            de_i,
    output logic            de_o,
    output logic [HSZ-1:0]  hcount_o,
    output logic [VSZ-1:0]  vcount_o,
    output logic            frame_o,
    output logic [HMSZ-1:0] h_total_o,
    output logic [HMSZ-1:0] h_active_o,
    output logic [HMSZ-1:0] h_sync_o,
    output logic [VMSZ-1:0] v_total_o,
    output logic [VMSZ-1:0] v_active_o,
    output logic [VMSZ-1:0] v_sync_o,
    output logic            lock_o
);
    localparam int MCW = $clog2(LOCK_FRAMES + 1);
    localparam logic [MCW-1:0] LOCK_CNT = MCW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic hs_r, vs_r, de_r, hs_q, vs_q, de_q;
    logic hs_fall, hs_rise, vs_fall, vs_rise, de_rise, de_fall;

    logic [HMSZ-1:0] hclk, line_tot, hs_wid, de_cnt, act_wid;
    logic [VMSZ-1:0] line_cnt, act_lines, vs_cnt, vs_wid;
    logic [HMSZ-1:0] h_total_new, h_active_new, h_sync_new;
    logic [VMSZ-1:0] v_total_new, v_active_new, v_sync_new;
    logic [HMSZ-1:0] prev_h_total, prev_h_active;
    logic [VMSZ-1:0] prev_v_total, prev_v_active;

    logic           prev_valid, prev_valid_nxt;
    logic [MCW-1:0] match_cnt, match_cnt_nxt;
    logic           lock_nxt, capture, match, watchdog;
    logic           de_nxt, first_line;

    function automatic logic [HMSZ-1:0] h_inc(input logic [HMSZ-1:0] v);
        return (v == '1) ? v : v + HMSZ'(1);
    endfunction

    function automatic logic [VMSZ-1:0] v_inc(input logic [VMSZ-1:0] v);
        return (v == '1) ? v : v + VMSZ'(1);
    endfunction

    assign hs_fall = hs_q & ~hs_r;
    assign hs_rise = ~hs_q & hs_r;
    assign vs_fall = vs_q & ~vs_r;
    assign vs_rise = ~vs_q & vs_r;
    assign de_rise = ~de_q & de_r;
    assign de_fall = de_q & ~de_r;

    // A line or sync edge landing on the frame edge belongs to the ending frame.
    assign h_total_new  = hs_fall ? hclk : line_tot;
    assign h_active_new = de_fall ? de_cnt : act_wid;
    assign h_sync_new   = hs_rise ? hclk : hs_wid;
    assign v_total_new  = hs_fall ? v_inc(line_cnt) : line_cnt;
    assign v_active_new = de_fall ? v_inc(act_lines) : act_lines;
    assign v_sync_new   = vs_rise ? vs_cnt : vs_wid;

    assign match = prev_valid &&
                   (h_total_new == prev_h_total) && (h_active_new == prev_h_active) &&
                   (v_total_new == prev_v_total) && (v_active_new == prev_v_active);
    assign watchdog = (hclk == '1) && !hs_fall;

    always_comb begin
        state_nxt      = state;
        match_cnt_nxt  = match_cnt;
        prev_valid_nxt = prev_valid;
        lock_nxt       = lock_o;
        capture        = 1'b0;
        if (watchdog) begin
            state_nxt      = S_SEARCH;
            match_cnt_nxt  = '0;
            prev_valid_nxt = 1'b0;
            lock_nxt       = 1'b0;
        end else if (vs_fall) begin
            case (state)
                S_SEARCH: begin
                    state_nxt = S_MEASURE;
                end
                S_MEASURE: begin
                    capture        = 1'b1;
                    prev_valid_nxt = 1'b1;
                    if (match) begin
                        match_cnt_nxt = match_cnt + MCW'(1);
                        if (match_cnt_nxt >= LOCK_CNT) begin
                            state_nxt = S_LOCKED;
                            lock_nxt  = 1'b1;
                        end
                    end else begin
                        match_cnt_nxt = '0;
                    end
                end
                S_LOCKED: begin
                    capture        = 1'b1;
                    prev_valid_nxt = 1'b1;
                    if (!match) begin
                        state_nxt     = S_MEASURE;
                        match_cnt_nxt = '0;
                        lock_nxt      = 1'b0;
                    end
                end
                default: begin
                    state_nxt = S_SEARCH;
                    lock_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign de_nxt = de_r && (state_nxt != S_SEARCH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            {hs_r, vs_r, de_r, hs_q, vs_q, de_q} <= '0;
            hclk          <= '0;
            line_tot      <= '0;
            hs_wid        <= '0;
            de_cnt        <= '0;
            act_wid       <= '0;
            line_cnt      <= '0;
            act_lines     <= '0;
            vs_cnt        <= '0;
            vs_wid        <= '0;
            prev_h_total  <= '0;
            prev_h_active <= '0;
            prev_v_total  <= '0;
            prev_v_active <= '0;
            prev_valid    <= 1'b0;
            match_cnt     <= '0;
            lock_o        <= 1'b0;
            frame_o       <= 1'b0;
            h_total_o     <= '0;
            h_active_o    <= '0;
            h_sync_o      <= '0;
            v_total_o     <= '0;
            v_active_o    <= '0;
            v_sync_o      <= '0;
            de_o          <= 1'b0;
            hcount_o      <= '0;
            vcount_o      <= '0;
            first_line    <= 1'b0;
        end else begin
            {hs_r, vs_r, de_r} <= {hsync_i, vsync_i, de_i};
            {hs_q, vs_q, de_q} <= {hs_r, vs_r, de_r};

            if (hs_fall) begin
                line_tot <= hclk;
                hclk     <= HMSZ'(1);
            end else begin
                hclk <= h_inc(hclk);
            end
            if (hs_rise) hs_wid <= hclk;

            if (de_rise)     de_cnt <= HMSZ'(1);
            else if (de_r)   de_cnt <= h_inc(de_cnt);
            if (de_fall)     act_wid <= de_cnt;

            if (vs_fall) begin
                line_cnt  <= '0;
                act_lines <= '0;
                vs_cnt    <= VMSZ'(hs_fall);
            end else begin
                line_cnt  <= v_total_new;
                act_lines <= v_active_new;
                if (hs_fall && !vs_r) vs_cnt <= v_inc(vs_cnt);
            end
            if (vs_rise) vs_wid <= vs_cnt;

            frame_o    <= vs_fall;
            lock_o     <= lock_nxt;
            match_cnt  <= match_cnt_nxt;
            prev_valid <= prev_valid_nxt;
            if (capture) begin
                h_total_o     <= h_total_new;
                h_active_o    <= h_active_new;
                h_sync_o      <= h_sync_new;
                v_total_o     <= v_total_new;
                v_active_o    <= v_active_new;
                v_sync_o      <= v_sync_new;
                prev_h_total  <= h_total_new;
                prev_h_active <= h_active_new;
                prev_v_total  <= v_total_new;
                prev_v_active <= v_active_new;
            end

            de_o <= de_nxt;
            if (de_nxt) hcount_o <= de_o ? hcount_o + HSZ'(1) : '0;
            if (de_nxt && !de_o) begin
                vcount_o   <= first_line ? '0 : vcount_o + VSZ'(1);
                first_line <= 1'b0;
            end
            if (vs_fall) first_line <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_timing_detect.sv
// Directed bench for vga_timing_detect driven by a small 16/2/4/3 x 8/1/2/2
// timing generator; expectations are hand-derived from that geometry.
module tb_vga_timing_detect;
    localparam int HSZ  = 10;
    localparam int VSZ  = 9;
    localparam int HMSZ = 12;
    localparam int VMSZ = 11;

    logic clk_i = 1'b0;
    logic rst_i, hsync_i, vsync_i, de_i;
    logic de_o, frame_o, lock_o;
    logic [HSZ-1:0]  hcount_o;
    logic [VSZ-1:0]  vcount_o;
    logic [HMSZ-1:0] h_total_o, h_active_o, h_sync_o;
    logic [VMSZ-1:0] v_total_o, v_active_o, v_sync_o;

    always #5 clk_i = ~clk_i;

    vga_timing_detect #(
        .HSZ(HSZ), .VSZ(VSZ), .HMSZ(HMSZ), .VMSZ(VMSZ), .LOCK_FRAMES(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i),
        .de_o(de_o), .hcount_o(hcount_o), .vcount_o(vcount_o), .frame_o(frame_o),
        .h_total_o(h_total_o), .h_active_o(h_active_o), .h_sync_o(h_sync_o),
        .v_total_o(v_total_o), .v_active_o(v_active_o), .v_sync_o(v_sync_o),
        .lock_o(lock_o)
    );

    int compared = 0;
    int mismatched = 0;
    int hpos, vpos, h_bp;
    bit gen_on, de_kill, chk_delay, de_any;
    int cyc, last_frame_cyc, frame_gap, delay_bad, n;
    int de_run, first_h, first_v, last_h, last_v;
    int de_frame, fr_first_h, fr_first_v, fr_last_h, fr_last_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One pixel clock: drive generator pins, clock, then observe outputs.
    task automatic step();
        logic de_prev;
        int h_tot;
        de_prev = de_i;
        h_tot = 22 + h_bp;
        if (gen_on) begin
            hsync_i = (hpos >= 18 && hpos < 22) ? 1'b0 : 1'b1;
            vsync_i = ((vpos == 9 && hpos >= 18) || vpos == 10 || (vpos == 11 && hpos < 18)) ? 1'b0 : 1'b1;
            de_i    = (!de_kill && hpos < 16 && vpos < 8) ? 1'b1 : 1'b0;
        end else begin
            hsync_i = 1'b1;
            vsync_i = 1'b1;
            de_i    = 1'b0;
        end
        @(posedge clk_i);
        #1;
        cyc++;
        if (gen_on) begin
            hpos++;
            if (hpos >= h_tot) begin
                hpos = 0;
                vpos = (vpos + 1) % 13;
            end
        end
        if (chk_delay && de_o !== de_prev) delay_bad++;
        if (de_o === 1'b1) begin
            if (de_run == 0) begin
                first_h = int'(hcount_o);
                first_v = int'(vcount_o);
            end
            last_h = int'(hcount_o);
            last_v = int'(vcount_o);
            de_run++;
        end
        if (frame_o === 1'b1) begin
            frame_gap = cyc - last_frame_cyc;
            last_frame_cyc = cyc;
            de_frame = de_run;
            fr_first_h = first_h;
            fr_first_v = first_v;
            fr_last_h = last_h;
            fr_last_v = last_v;
            de_run = 0;
        end
    endtask

    task automatic wait_frame(input string tag, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            got = (frame_o === 1'b1);
        end
        check(tag, 32'(got), 1);
    endtask

    task automatic check_geom(input string tag, input int ht, input int ha, input int hs,
                              input int vt, input int va, input int vs);
        check({tag, "_h_total"}, 32'(h_total_o), ht);
        check({tag, "_h_active"}, 32'(h_active_o), ha);
        check({tag, "_h_sync"}, 32'(h_sync_o), hs);
        check({tag, "_v_total"}, 32'(v_total_o), vt);
        check({tag, "_v_active"}, 32'(v_active_o), va);
        check({tag, "_v_sync"}, 32'(v_sync_o), vs);
    endtask

    initial begin
        rst_i = 1'b1;
        hsync_i = 1'b1;
        vsync_i = 1'b1;
        de_i = 1'b0;
        gen_on = 1'b0;
        de_kill = 1'b0;
        chk_delay = 1'b0;
        h_bp = 3;
        hpos = 0;
        vpos = 0;
        cyc = 0;
        last_frame_cyc = 0;
        delay_bad = 0;
        de_run = 0;

        repeat (3) step();
        check("rst_de", 32'(de_o), 0);
        check("rst_frame", 32'(frame_o), 0);
        check("rst_lock", 32'(lock_o), 0);
        check("rst_hcount", 32'(hcount_o), 0);
        check("rst_vcount", 32'(vcount_o), 0);
        check_geom("rst", 0, 0, 0, 0, 0, 0);

        // Acquisition: measurements from the 2nd edge, lock on the 4th.
        rst_i = 1'b0;
        gen_on = 1'b1;
        wait_frame("frame1", 400);
        wait_frame("frame2", 400);
        check("frame2_gap", 32'(frame_gap), 325);
        check_geom("frame2", 25, 16, 4, 13, 8, 2);
        check("frame2_lock", 32'(lock_o), 0);
        wait_frame("frame3", 400);
        check("frame3_lock", 32'(lock_o), 0);
        wait_frame("frame4", 400);
        check("frame4_lock", 32'(lock_o), 1);
        check("frame4_gap", 32'(frame_gap), 325);

        // Locked position recovery and 2-clock de latency.
        chk_delay = 1'b1;
        delay_bad = 0;
        wait_frame("frame5", 400);
        chk_delay = 1'b0;
        check("pos_de_count", 32'(de_frame), 128);
        check("pos_first_h", 32'(fr_first_h), 0);
        check("pos_first_v", 32'(fr_first_v), 0);
        check("pos_last_h", 32'(fr_last_h), 15);
        check("pos_last_v", 32'(fr_last_v), 7);
        check("de_delay_errors", 32'(delay_bad), 0);
        check("frame5_lock", 32'(lock_o), 1);

        // Sync loss: watchdog drops lock, measurements hold.
        gen_on = 1'b0;
        de_any = 1'b0;
        n = 0;
        while (lock_o === 1'b1 && n < 5000) begin
            step();
            n++;
            if (de_o !== 1'b0) de_any = 1'b1;
        end
        repeat (20) begin
            step();
            if (de_o !== 1'b0) de_any = 1'b1;
        end
        check("wd_lock", 32'(lock_o), 0);
        check("wd_latency_ok", 32'(n <= 4096), 1);
        check("wd_de_quiet", 32'(de_any), 0);
        check_geom("wd_hold", 25, 16, 4, 13, 8, 2);

        // Restart and relock.
        hpos = 0;
        vpos = 0;
        gen_on = 1'b1;
        wait_frame("rs_frameA", 4500);
        wait_frame("rs_frameB", 400);
        wait_frame("rs_frameC", 400);
        check("rs_frameC_lock", 32'(lock_o), 0);
        wait_frame("rs_frameD", 400);
        check("rs_frameD_lock", 32'(lock_o), 1);

        // Back porch 3 -> 4.
        h_bp = 4;
        wait_frame("bp_frameE", 400);
        check("bp_frameE_lock", 32'(lock_o), 0);
        check("bp_frameE_h_total", 32'(h_total_o), 26);
        wait_frame("bp_frameF", 400);
        check("bp_frameF_lock", 32'(lock_o), 0);
        wait_frame("bp_frameG", 400);
        check("bp_frameG_lock", 32'(lock_o), 1);
        check("bp_frameG_h_total", 32'(h_total_o), 26);

        // Whole frame with de held low.
        de_kill = 1'b1;
        wait_frame("nde_frameH", 400);
        de_kill = 1'b0;
        check("nde_v_active", 32'(v_active_o), 0);
        check("nde_h_active", 32'(h_active_o), 16);
        check("nde_v_total", 32'(v_total_o), 13);
        check("nde_lock", 32'(lock_o), 0);

        // Reset pulse in the middle of an active line.
        n = 0;
        while (!(vpos == 2 && hpos == 5) && n < 1000) begin
            step();
            n++;
        end
        check("pre_rst_de", 32'(de_o), 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("mrst_de", 32'(de_o), 0);
        check("mrst_hcount", 32'(hcount_o), 0);
        check("mrst_vcount", 32'(vcount_o), 0);
        check("mrst_frame", 32'(frame_o), 0);
        check("mrst_lock", 32'(lock_o), 0);
        check_geom("mrst", 0, 0, 0, 0, 0, 0);
        de_any = 1'b0;
        n = 0;
        do begin
            step();
            n++;
            if (frame_o !== 1'b1 && de_o !== 1'b0) de_any = 1'b1;
        end while (frame_o !== 1'b1 && n < 400);
        check("mrst_first_frame", 32'(frame_o), 1);
        check("mrst_de_quiet", 32'(de_any), 0);
        wait_frame("mrst_frame2", 400);
        check("mrst_de_count", 32'(de_frame), 128);
        check("mrst_first_h", 32'(fr_first_h), 0);
        check("mrst_first_v", 32'(fr_first_v), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
